// File: rtl/video_pixel_fifo.sv
// -----------------------------------------------------------------------------
// video_pixel_fifo
//   Single-clock pixel FIFO between the PPU pixel stage and the video output /
//   debugger capture path. Width and depth are configurable. The read port runs
//   in first-word-fall-through (FWFT) or standard registered mode. The FIFO
//   reports its occupancy and has programmable almost-full and almost-empty
//   flags, sticky overflow and underflow flags, and a synchronous flush.
//
// Parameters
//   DATA_WIDTH          entry width (default 24 = {R,G,B})
//   ADDR_WIDTH          depth = 2**ADDR_WIDTH entries, 1..10
//   FWFT                1 = head entry always visible, 0 = registered read
//   ALMOST_FULL_LEVEL   o_almost_full  when level >= this, 1..depth
//   ALMOST_EMPTY_LEVEL  o_almost_empty when level <= this, 0..depth-1
//
// Ports
//   i_clk, i_reset_n    clock (rising edge) and async active-low reset
//   i_clear             synchronous flush; also clears the sticky flags
//   i_wr_en, i_wr_data  write request and data
//   o_full              level == depth
//   o_almost_full       level >= ALMOST_FULL_LEVEL
//   i_rd_en             read request (FWFT: acknowledge of the head entry)
//   o_rd_data           read data
//   o_rd_valid          o_rd_data holds a valid entry
//   o_empty             level == 0
//   o_almost_empty      level <= ALMOST_EMPTY_LEVEL
//   o_level             occupancy, 0..depth
//   o_overflow          sticky: a write was attempted while full
//   o_underflow         sticky: a read was attempted while empty
//
// Handshake: a write is accepted on a rising edge when i_wr_en=1 and the
// registered o_full=0. A read is accepted when i_rd_en=1 and the registered
// o_empty=0. Neither side looks at what the other does in the same cycle. A
// write while full is refused even if a read drains an entry on that edge,
// and a read while empty is refused even if a write fills one. A refused
// request only sets its sticky error flag. In FWFT mode, o_rd_valid acts as
// "valid" and i_rd_en acts as "ready" for the head entry.
// -----------------------------------------------------------------------------
module video_pixel_fifo #(
    parameter int DATA_WIDTH         = 24,
    parameter int ADDR_WIDTH         = 4,
    parameter int FWFT               = 1,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    output logic                  o_almost_full,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] LVL_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AF    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] LVL_AE    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0] LVL_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic                  wr_accept;
    logic                  rd_accept;

    // All flags are decoded from the registered level.
    assign o_full         = (level == LVL_DEPTH);
    assign o_empty        = (level == '0);
    assign o_almost_full  = (level >= LVL_AF);
    assign o_almost_empty = (level <= LVL_AE);
    assign o_level        = level;

    assign wr_accept = i_wr_en && !o_full;
    assign rd_accept = i_rd_en && !o_empty;

    // Pointers, level and sticky flags
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_accept && !rd_accept) begin
                level <= level + LVL_ONE;
            end else if (rd_accept && !wr_accept) begin
                level <= level - LVL_ONE;
            end
            if (i_wr_en && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_en && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end

    // Storage. A flush leaves the contents in place; only reset zeroes them.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!i_clear && wr_accept) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Read port
    if (FWFT != 0) begin : g_fwft
        // The head entry is always presented. Reset zeroes the array, so the
        // data bus reads 0 after reset without needing a register of its own.
        assign o_rd_data  = mem[rd_ptr];
        assign o_rd_valid = !o_empty;
    end else begin : g_std
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                o_rd_data  <= '0;
                o_rd_valid <= 1'b0;
            end else if (i_clear) begin
                o_rd_valid <= 1'b0;
            end else begin
                o_rd_valid <= rd_accept;
                if (rd_accept) begin
                    o_rd_data <= mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_video_pixel_fifo.sv
// -----------------------------------------------------------------------------
// tb_video_pixel_fifo
//   Drives one FWFT instance and one standard-mode instance with the same
//   stimulus. Both are checked every cycle against a queue-based model of the
//   FIFO.
// -----------------------------------------------------------------------------
module tb_video_pixel_fifo;

    localparam int W     = 24;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;

    logic          f_full, f_af, f_rv, f_empty, f_ae, f_ovf, f_udf;
    logic [W-1:0]  f_rd_data;
    logic [AW:0]   f_level;
    logic          s_full, s_af, s_rv, s_empty, s_ae, s_ovf, s_udf;
    logic [W-1:0]  s_rd_data;
    logic [AW:0]   s_level;

    video_pixel_fifo #(
        .DATA_WIDTH(W), .ADDR_WIDTH(AW), .FWFT(1),
        .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE)
    ) u_fwft (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear),
        .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(f_full), .o_almost_full(f_af),
        .i_rd_en(rd_en), .o_rd_data(f_rd_data), .o_rd_valid(f_rv),
        .o_empty(f_empty), .o_almost_empty(f_ae), .o_level(f_level),
        .o_overflow(f_ovf), .o_underflow(f_udf)
    );

    video_pixel_fifo #(
        .DATA_WIDTH(W), .ADDR_WIDTH(AW), .FWFT(0),
        .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE)
    ) u_std (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear),
        .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(s_full), .o_almost_full(s_af),
        .i_rd_en(rd_en), .o_rd_data(s_rd_data), .o_rd_valid(s_rv),
        .o_empty(s_empty), .o_almost_empty(s_ae), .o_level(s_level),
        .o_overflow(s_ovf), .o_underflow(s_udf)
    );

    // scoreboard / reference model
    logic [W-1:0] exp_q[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    logic         m_std_valid = 1'b0;
    logic [W-1:0] m_std_data = '0;

    int check_count = 0;
    int pass_count  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        m_std_valid = 1'b0;
        m_std_data  = '0;
    endtask

    // Compare both instances against the model.
    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        check({tag, " f_level"}, 32'(f_level), 32'(n));
        check({tag, " s_level"}, 32'(s_level), 32'(n));
        check({tag, " f_empty"}, 32'(f_empty), 32'(n == 0));
        check({tag, " s_empty"}, 32'(s_empty), 32'(n == 0));
        check({tag, " f_full"},  32'(f_full),  32'(n == DEPTH));
        check({tag, " s_full"},  32'(s_full),  32'(n == DEPTH));
        check({tag, " f_af"},    32'(f_af),    32'(n >= AF));
        check({tag, " s_af"},    32'(s_af),    32'(n >= AF));
        check({tag, " f_ae"},    32'(f_ae),    32'(n <= AE));
        check({tag, " s_ae"},    32'(s_ae),    32'(n <= AE));
        check({tag, " f_ovf"},   32'(f_ovf),   32'(m_ovf));
        check({tag, " s_ovf"},   32'(s_ovf),   32'(m_ovf));
        check({tag, " f_udf"},   32'(f_udf),   32'(m_udf));
        check({tag, " s_udf"},   32'(s_udf),   32'(m_udf));
        check({tag, " f_valid"}, 32'(f_rv),    32'(n != 0));
        if (n != 0) begin
            check({tag, " f_data"}, 32'(f_rd_data), 32'(exp_q[0]));
        end
        check({tag, " s_valid"}, 32'(s_rv),      32'(m_std_valid));
        check({tag, " s_data"},  32'(s_rd_data), 32'(m_std_data));
    endtask

    // driver: one clock cycle of stimulus; called at a falling edge,
    // returns at the next falling edge after the outputs have been checked
    task automatic step(input logic wr, input logic [W-1:0] d, input logic rd,
                        input logic clr, input string tag);
        logic w_ok;
        logic r_ok;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        clear   = clr;
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
            m_ovf       = 1'b0;
            m_udf       = 1'b0;
            m_std_valid = 1'b0;
        end else begin
            w_ok = wr && (exp_q.size() < DEPTH);
            r_ok = rd && (exp_q.size() != 0);
            if (wr && !w_ok) m_ovf = 1'b1;
            if (rd && !r_ok) m_udf = 1'b1;
            m_std_valid = r_ok;
            if (r_ok) m_std_data = exp_q.pop_front();
            if (w_ok) exp_q.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset_idle");

        // FWFT head visibility
        step(1'b1, 24'h112233, 1'b0, 1'b0, "wr_112233");
        step(1'b0, '0, 1'b1, 1'b0, "rd_112233");

        // Standard mode: one-cycle read latency, data in order
        step(1'b1, 24'h00000A, 1'b0, 1'b0, "wr_a");
        step(1'b1, 24'h00000B, 1'b0, 1'b0, "wr_b");
        step(1'b1, 24'h00000C, 1'b0, 1'b0, "wr_c");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "rd_abc");
        step(1'b0, '0, 1'b0, 1'b0, "idle_after_abc");

        // Fill to full, overflow, drain across the pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, "fill");
        step(1'b1, 24'hDEAD01, 1'b0, 1'b0, "wr_17th");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");

        // Simultaneous write and read at full and at empty
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, "fill2");
        step(1'b1, 24'hBEEF00, 1'b1, 1'b0, "wr_rd_full");
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0, "drain2");
        step(1'b1, 24'h0FACE0, 1'b1, 1'b0, "wr_rd_empty");

        // Flush at level 5 with the sticky flags set; the write is ignored
        for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, "to_lvl5");
        step(1'b1, 24'h123456, 1'b1, 1'b1, "clear_wr");
        step(1'b0, '0, 1'b0, 1'b0, "after_clear");

        // Async reset between edges, in the middle of a burst
        for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), (i > 2), 1'b0, "burst");
        wr_en = 1'b1;
        rd_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_all("after_reset");

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            logic wr;
            logic rd;
            logic clr;
            wr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            rd  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            clr = ($urandom_range(0, 59) == 0);
            step(wr, W'($urandom), rd, clr, "rand");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
